// File: rtl/vga_fb_ctrl_if.sv
// Framebuffer read port shared by vga_fb_ctrl (master) and the pixel memory
// (slave). The address and enable are registered by the master. Read data
// must be returned a fixed number of clocks later; the master's
// MEM_LATENCY parameter sets that number.
interface vga_fb_ctrl_if;
  logic        fb_rd_en;
  logic [9:0]  fb_addr_h;
  logic [8:0]  fb_addr_v;
  logic [23:0] fb_rdata;

  modport master (
    output fb_rd_en,
    output fb_addr_h,
    output fb_addr_v,
    input  fb_rdata
  );

  modport slave (
    input  fb_rd_en,
    input  fb_addr_h,
    input  fb_addr_v,
    output fb_rdata
  );
endinterface

// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: parametrised VGA timing generator and framebuffer pixel fetcher.
// The mode timing is set by parameters. Read addresses go out one clock after
// the counters. Sync, blanking and frame_start travel down a delay line that
// matches the memory read latency, so every pin changes MEM_LATENCY+2 clocks
// after the counters.
// Optional feature: define VGA_FB_TEST_PATTERN_EN to add built-in colour bars,
// selected per pixel by test_mode.
module vga_fb_ctrl #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          H_POL       = 1'b0,
  parameter bit          V_POL       = 1'b0,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  vga_fb_ctrl_if.master       fb,
  input  logic                test_mode,
  output logic                hsync,
  output logic                vsync,
  output logic                valid,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  // Per-pixel control that rides alongside an outstanding read. Sync bits are
  // held as "active" flags; the polarity is applied only at the pins.
  typedef struct packed {
    logic       vis;
    logic       hs;
    logic       vs;
    logic       first;
`ifdef VGA_FB_TEST_PATTERN_EN
    logic       tm;
    logic [2:0] bar;
`endif
  } ctl_t;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [31:0]   hc32, vc32;

  ctl_t          ctl_d;
  ctl_t          ctl_p0_q;
  ctl_t          ctl_dly_q [1:MEM_LATENCY];
  ctl_t          ctl_o;

  logic          rd_en_d;
  logic [9:0]    addr_h_d;
  logic [8:0]    addr_v_d;
  logic [23:0]   pix_d;

  logic          hsync_q, vsync_q, valid_q, frame_start_q;
  logic [23:0]   rgb_q;

`ifdef VGA_FB_TEST_PATTERN_EN
  // Colours of the 8 bars, from left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  // Raster counters: the line wrap and the frame wrap can happen on the same edge.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (hcnt_q == HW'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      if (vcnt_q == VW'(V_TOTAL - 1)) vcnt_d = '0;
      else                            vcnt_d = vcnt_q + VW'(1);
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  // Counter registers. Reset restarts the frame at pixel (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Decode the pixel position from the counters. The comparisons use 32 bits
  // so that a boundary equal to the total does not wrap.
  assign hc32 = 32'(hcnt_q);
  assign vc32 = 32'(vcnt_q);

  // Build the control word for this pixel, and the framebuffer address if it is visible.
  always_comb begin
    ctl_d       = '0;
    ctl_d.vis   = (hc32 < H_ACTIVE) && (vc32 < V_ACTIVE);
    ctl_d.hs    = (hc32 >= H_ACTIVE + H_FP) && (hc32 < H_ACTIVE + H_FP + H_SYNC);
    ctl_d.vs    = (vc32 >= V_ACTIVE + V_FP) && (vc32 < V_ACTIVE + V_FP + V_SYNC);
    ctl_d.first = (hcnt_q == '0) && (vcnt_q == '0);
`ifdef VGA_FB_TEST_PATTERN_EN
    ctl_d.tm    = test_mode;
    ctl_d.bar   = 3'((hc32 * 32'd8) / H_ACTIVE);
    rd_en_d     = ctl_d.vis && !test_mode;
`else
    rd_en_d     = ctl_d.vis;
`endif
    addr_h_d    = ctl_d.vis ? 10'(hcnt_q >> SCALE_SHIFT) : '0;
    addr_v_d    = ctl_d.vis ? 9'(vcnt_q >> SCALE_SHIFT) : '0;
  end

  // ---- stage 0: issue the read and register the pixel's control word ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_p0_q     <= '0;
      fb.fb_rd_en  <= 1'b0;
      fb.fb_addr_h <= '0;
      fb.fb_addr_v <= '0;
    end else begin
      ctl_p0_q     <= ctl_d;
      fb.fb_rd_en  <= rd_en_d;
      fb.fb_addr_h <= addr_h_d;
      fb.fb_addr_v <= addr_v_d;
    end
  end

  // ---- stages 1..MEM_LATENCY: control waits while the read is in flight ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= int'(MEM_LATENCY); i++) ctl_dly_q[i] <= '0;
    end else begin
      ctl_dly_q[1] <= ctl_p0_q;
      for (int i = 2; i <= int'(MEM_LATENCY); i++) ctl_dly_q[i] <= ctl_dly_q[i-1];
    end
  end

  assign ctl_o = ctl_dly_q[MEM_LATENCY];

  // Pick the pixel source: the framebuffer, or a bar colour in test mode.
  always_comb begin
    pix_d = fb.fb_rdata;
`ifdef VGA_FB_TEST_PATTERN_EN
    if (ctl_o.tm) pix_d = bar_colour(ctl_o.bar);
`endif
  end

  // ---- output stage: register the pins; colour is forced to 0 while blanked ----
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      hsync_q       <= ctl_o.hs ? H_POL : ~H_POL;
      vsync_q       <= ctl_o.vs ? V_POL : ~V_POL;
      valid_q       <= ctl_o.vis;
      frame_start_q <= ctl_o.first;
      rgb_q         <= ctl_o.vis ? pix_d : '0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign frame_start = frame_start_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Testbench for vga_fb_ctrl. It runs two instances with a small test mode,
// one unscaled and one with SCALE_SHIFT=1, against a reference model.
// For each clock the model works out the raster position from the number of
// clocks since the last reset, then gives the expected fetch outputs and pin
// outputs. Stimulus is random test_mode, random reset pulses, random memory
// contents, and one reset placed in the middle of line 2.
`timescale 1ns/1ps
module tb_vga_fb_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int ML = 2;
  localparam int L  = ML + 2;

  logic clk = 1'b0;
  logic rst;
  logic test_mode;
  always #5 clk = ~clk;

  vga_fb_ctrl_if fbif0 ();
  vga_fb_ctrl_if fbif1 ();

  logic       hs0, vs0, vl0, fs0, hs1, vs1, vl1, fs1;
  logic [7:0] r0, g0, b0, r1, g1, b1;

  vga_fb_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .SCALE_SHIFT(0), .MEM_LATENCY(ML)
  ) dut0 (
    .clk(clk), .rst(rst), .fb(fbif0), .test_mode(test_mode),
    .hsync(hs0), .vsync(vs0), .valid(vl0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .frame_start(fs0)
  );

  vga_fb_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .SCALE_SHIFT(1), .MEM_LATENCY(ML)
  ) dut1 (
    .clk(clk), .rst(rst), .fb(fbif1), .test_mode(test_mode),
    .hsync(hs1), .vsync(vs1), .valid(vl1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1)
  );

  // Behavioural framebuffer, indexed [row][column].
  logic [23:0] mem [0:VA-1][0:HA-1];
  logic [23:0] m0_a, m0_b, m1_a, m1_b;

  function automatic logic [23:0] mem_rd(input logic en, input logic [9:0] h, input logic [8:0] v);
    if (en !== 1'b1)          return 24'hA5A5A5;
    if (h < HA && v < VA)     return mem[v[1:0]][h[2:0]];
    return 24'h5A5A5A;
  endfunction

  // Read data comes back ML clocks after the address is presented.
  always @(posedge clk) begin
    m0_a <= mem_rd(fbif0.fb_rd_en, fbif0.fb_addr_h, fbif0.fb_addr_v);
    m0_b <= m0_a;
    m1_a <= mem_rd(fbif1.fb_rd_en, fbif1.fb_addr_h, fbif1.fb_addr_v);
    m1_b <= m1_a;
  end
  assign fbif0.fb_rdata = m0_b;
  assign fbif1.fb_rdata = m1_b;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  bit started  = 1'b0;
  bit tm_hist [0:8191];
  int fs_last  = -1;
  int vcount   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d after reset)", tag, obs, exp, n);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic bit tm_eff(input int k);
`ifdef VGA_FB_TEST_PATTERN_EN
    if (k < 8192) return tm_hist[k];
    return 1'b0;
`else
    return (k < 0);
`endif
  endfunction

  // Compare one DUT with the model. Fetch outputs show counter cycle n-1;
  // pin outputs show counter cycle n-L.
  task automatic check_dut(input string nm, input int s,
                           input logic hs, input logic vs, input logic vl, input logic fs,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic rd, input logic [9:0] ah, input logic [8:0] av);
    int k, h, v;
    bit vis, t;
    logic ehs, evs, evl, efs;
    logic [23:0] ergb;
    if (n >= 1) begin
      k = n - 1; h = k % HT; v = (k / HT) % VT;
      vis = (h < HA) && (v < VA); t = tm_eff(k);
      check_eq({nm, ".fb_rd_en"}, rd, vis && !t);
      check_eq({nm, ".fb_addr_h"}, ah, vis ? (h >> s) : 0);
      check_eq({nm, ".fb_addr_v"}, av, vis ? (v >> s) : 0);
    end else begin
      check_eq({nm, ".fb_rd_en_rst"}, rd, 0);
      check_eq({nm, ".fb_addr_h_rst"}, ah, 0);
      check_eq({nm, ".fb_addr_v_rst"}, av, 0);
    end
    ehs = 1'b1; evs = 1'b1; evl = 1'b0; efs = 1'b0; ergb = 24'h0;
    if (n >= L) begin
      k = n - L; h = k % HT; v = (k / HT) % VT;
      vis = (h < HA) && (v < VA); t = tm_eff(k);
      ehs = !(h >= HA + HF && h < HA + HF + HS);
      evs = !(v >= VA + VF && v < VA + VF + VS);
      evl = vis;
      efs = (h == 0) && (v == 0);
      if (vis) ergb = t ? bar_rgb(h * 8 / HA) : mem[v >> s][h >> s];
    end
    check_eq({nm, ".hsync"}, hs, ehs);
    check_eq({nm, ".vsync"}, vs, evs);
    check_eq({nm, ".valid"}, vl, evl);
    check_eq({nm, ".frame_start"}, fs, efs);
    check_eq({nm, ".rgb"}, {r, g, b}, ergb);
  endtask

  // Whole-frame properties on the unscaled instance: the frame period, the
  // number of visible pixels per frame, and the latency of the first frame_start.
  task automatic frame_checks();
    if (n == 0) begin
      fs_last = -1;
      vcount  = 0;
    end else begin
      if (n == L) check_eq("first_frame_start", fs0, 1);
      if (fs0 === 1'b1) begin
        if (fs_last >= 0) begin
          check_eq("frame_period", n - fs_last, 128);
          check_eq("valid_per_frame", vcount, 32);
        end
        fs_last = n;
        vcount  = (vl0 === 1'b1) ? 1 : 0;
      end else if (vl0 === 1'b1) begin
        vcount++;
      end
    end
  endtask

  task automatic step(input bit r, input bit tm);
    @(negedge clk);
    rst = r;
    test_mode = tm;
    if (n < 8192) tm_hist[n] = tm;
    @(posedge clk);
    if (r) n = 0;
    else   n = n + 1;
    if (r) started = 1'b1;
    #1;
    if (started) begin
      check_dut("u0", 0, hs0, vs0, vl0, fs0, r0, g0, b0,
                fbif0.fb_rd_en, fbif0.fb_addr_h, fbif0.fb_addr_v);
      check_dut("u1", 1, hs1, vs1, vl1, fs1, r1, g1, b1,
                fbif1.fb_rd_en, fbif1.fb_addr_h, fbif1.fb_addr_v);
      frame_checks();
    end
  endtask

  initial begin
    for (int v = 0; v < VA; v++)
      for (int h = 0; h < HA; h++)
        mem[v][h] = {8'(v), 8'(h), 8'($urandom_range(0, 255))};
    mem[2][3] = 24'h123456;
    rst = 1'b1;
    test_mode = 1'b0;

    repeat (3) step(1'b1, 1'b0);
    // Several undisturbed frames with test_mode set only now and then.
    repeat (400) step(1'b0, $urandom_range(0, 3) == 0);
    // A single-cycle reset while the counters are at line 2, pixel 5.
    step(1'b1, 1'b0);
    repeat (37) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (300) step(1'b0, 1'b0);
    // Random resets and random test_mode.
    repeat (2000) step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_fb_ctrl.md
# vga_fb_ctrl

Parametrised VGA timing generator and frame-buffer pixel fetcher, succeeding the fixed 640x480 controller/vmem pair in the board top. Generates sync and blanking for any mode set by parameters, issues framebuffer read addresses, tolerates a configurable memory read latency, and optionally pixel-doubles by power-of-two scaling. Sits between the framebuffer memory and the VGA_* board pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal porch/sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP, 10; V_SYNC, 2; V_BP, 33: vertical porch/sync widths in lines
- H_POL, 0; V_POL, 0: sync active level
- SCALE_SHIFT, 0: address = counter >> SCALE_SHIFT, range 0..3
- MEM_LATENCY, 1: clocks from fb_addr_h/v to valid fb_rdata, range 1..4
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- fb_rdata  in  24  pixel from framebuffer, {R,G,B}
- test_mode  in  1  select built-in colour bars (see Configuration)
- fb_rd_en  out  1  high when fb_addr_h/v address a visible pixel
- fb_addr_h  out  10  framebuffer column
- fb_addr_v  out  9  framebuffer row
- hsync, vsync  out  1  sync outputs, level per H_POL/V_POL
- valid  out  1  visible-region flag (drives VGA_BLANK_N)
- vga_r, vga_g, vga_b  out  8  colour
- frame_start  out  1  one-cycle pulse aligned with first visible pixel of a frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- hcnt counts 0..H_TOTAL-1, wraps to 0; vcnt increments on hcnt wrap, wraps 0 after V_TOTAL-1.
- Visible: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- hsync active while H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync active while V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
- Stage 0 (registered from counters): fb_addr_h = hcnt>>SCALE_SHIFT, fb_addr_v = vcnt>>SCALE_SHIFT, truncated to port width; fb_rd_en = visible. Outside visible region addresses hold 0.
- Delay line of MEM_LATENCY stages carries hsync, vsync, visible, first-pixel flag alongside the outstanding read.
- Output stage (registered): valid = delayed visible; rgb = fb_rdata split {R[23:16],G[15:8],B[7:0]} when valid, else 0.
- frame_start = delayed (hcnt==0 && vcnt==0) flag.
- No stall; fb_rdata must be valid exactly MEM_LATENCY clocks after address.

## Timing
- Reset (rst high at a clk edge): hcnt=vcnt=0, whole delay line cleared; outputs next cycle: hsync=~H_POL, vsync=~V_POL, valid=0, rgb=0, frame_start=0, fb_rd_en=0, fb_addr_h/v=0.
- Reset mid-line/mid-frame: same as above; first frame restarts at hcnt=vcnt=0 with no partial pixels emitted after reset deasserts.
- Counter-to-pin latency L = MEM_LATENCY+2 clocks for sync, valid, rgb and frame_start equally; fb_addr/fb_rd_en lag counters by 1 clock.
- After rst falls, first frame_start appears L clocks later.
- Line wrap and frame wrap on same edge: hcnt->0, vcnt->0 together; no extra line.
- SCALE_SHIFT=1: each address repeated on 2 consecutive pixels and 2 consecutive lines.

## Configuration
- VGA_FB_TEST_PATTERN_EN defined: when test_mode=1, output rgb replaced by 8 vertical colour bars (index = hcnt*8/H_ACTIVE, colours white, yellow, cyan, green, magenta, red, blue, black), fully delayed to same latency; fb_rd_en forced 0. test_mode sampled per pixel.
- Not defined: test_mode ignored, no bar logic synthesised; behaviour identical to test_mode=0.

## Test plan
Bench parameters: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), MEM_LATENCY=2, polarity 0, behavioural memory returning {v,h} pattern.
- Release rst -> frame_start at cycle 4 after release, valid high 8 clocks then low 8, hsync low at pixel positions 10..12 each line.
- Memory word at (h=3,v=2) = 0x123456 -> during that pixel vga_r=0x12, vga_g=0x34, vga_b=0x56; all rgb 0 when valid=0.
- Run 2 frames -> vsync low during lines 5..6, exactly 128 clocks between frame_start pulses, 32 valid pixels per frame.
- SCALE_SHIFT=1 -> fb_addr_h sequence 0,0,1,1,2,2,3,3 per line; fb_addr_v steps every 2 lines.
- Assert rst for 1 cycle mid-line 2 -> next cycle all outputs at reset values; frame restarts from (0,0), frame_start L clocks after release.
- With VGA_FB_TEST_PATTERN_EN, test_mode=1 -> pixel 0 = 0xFFFFFF, pixel 7 = 0x000000, fb_rd_en stays 0.
